pipeline_ctrl: RTL

Central stall/flush controller for the five-stage pipeline. It drives the Enable and flush inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles three cases: load-use hazards (one bubble), taken branches/jumps resolved in EX (squash two younger instructions) and multi-cycle data-memory waits (full freeze with timeout). It also keeps two saturating performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 20 ++
 rtl/pipeline_ctrl_hazard_detect.sv | 24 ++
 rtl/pipeline_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  localparam int unsigned REG_ADDR_W      = 5;
  localparam int unsigned MEM_TIMEOUT_DEF = 255;

  localparam int unsigned STALL_CNT_RST    = 0;
  localparam int unsigned REDIRECT_CNT_RST = 0;

  // Bit positions inside the ID/EX WB_control word.
  localparam int unsigned WB_MEMTOREG_BIT = 2;
  localparam int unsigned WB_REGWRITE_BIT = 3;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use compare between the ID sources and the EX load destination.
module pipeline_ctrl_hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  uses_rs1,
  input  logic                  uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  load_use_c
);

  logic rd_valid;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load into it never creates a dependency.
  assign rd_valid   = ex_mem_read && (ex_rd != '0);
  assign rs1_hit    = uses_rs1 && (rs1 == ex_rd);
  assign rs2_hit    = uses_rs2 && (rs2 == ex_rd);
  assign load_use_c = rd_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use bubbles, EX redirects,
// data-memory wait freeze with timeout fault, and saturating performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] ID_Rs1,
  input  logic [REG_ADDR_W-1:0] ID_Rs2,
  input  logic                  ID_UsesRs1,
  input  logic                  ID_UsesRs2,
  input  logic [REG_ADDR_W-1:0] EX_RegDst,
  input  logic                  EX_MemRead,
  input  logic                  EX_Redirect,
  input  logic                  MEM_Req,
  input  logic                  MEM_Ready,
  output logic                  PC_Enable,
  output logic                  IF_ID_Enable,
  output logic                  ID_EX_Enable,
  output logic                  EX_MEM_Enable,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_flush,
  output logic                  MEM_WB_flush,
  output logic                  MemError,
  output logic [CNT_W-1:0]      StallCycles,
  output logic [CNT_W-1:0]      RedirectCount
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state;
  state_e            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              mem_stall;
  logic              load_use;
  logic              redirect_taken;
  logic              stall_inc;

  assign mem_stall = MEM_Req && !MEM_Ready;

  pipeline_ctrl_hazard_detect u_hazard_detect (
    .rs1         (ID_Rs1),
    .rs2         (ID_Rs2),
    .uses_rs1    (ID_UsesRs1),
    .uses_rs2    (ID_UsesRs2),
    .ex_rd       (EX_RegDst),
    .ex_mem_read (EX_MemRead),
    .load_use_c  (load_use)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Enables and flushes reach the pipeline registers in the same cycle.
  always_comb begin
    state_nxt      = state;
    wait_nxt       = wait_cnt;
    PC_Enable      = 1'b1;
    IF_ID_Enable   = 1'b1;
    ID_EX_Enable   = 1'b1;
    EX_MEM_Enable  = 1'b1;
    IF_ID_flush    = 1'b0;
    ID_EX_flush    = 1'b0;
    MEM_WB_flush   = 1'b0;
    MemError       = 1'b0;
    redirect_taken = 1'b0;

    case (state)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_stall) begin
          PC_Enable     = 1'b0;
          IF_ID_Enable  = 1'b0;
          ID_EX_Enable  = 1'b0;
          EX_MEM_Enable = 1'b0;
          MEM_WB_flush  = 1'b1;
        end else if (EX_Redirect) begin
          // The ID instruction is squashed, so any load-use on it is moot.
          IF_ID_flush    = 1'b1;
          ID_EX_flush    = 1'b1;
          redirect_taken = 1'b1;
        end else if (load_use) begin
          PC_Enable    = 1'b0;
          IF_ID_Enable = 1'b0;
          ID_EX_flush  = 1'b1;
        end

        if (state == ST_RUN) begin
          if (mem_stall) begin
            state_nxt = ST_MEM_WAIT;
            wait_nxt  = WAIT_W'(1);
          end
        end else if (mem_stall) begin
          if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_nxt = ST_FAULT;
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end else begin
          // Ready, or a dropped request treated as ready.
          state_nxt = ST_RUN;
          wait_nxt  = '0;
        end
      end
      ST_FAULT: begin
        PC_Enable     = 1'b0;
        IF_ID_Enable  = 1'b0;
        ID_EX_Enable  = 1'b0;
        EX_MEM_Enable = 1'b0;
        MemError      = 1'b1;
      end
      default: begin
        state_nxt = ST_RUN;
        wait_nxt  = '0;
      end
    endcase

    if (!RESET) begin
      PC_Enable      = 1'b0;
      IF_ID_Enable   = 1'b0;
      ID_EX_Enable   = 1'b0;
      EX_MEM_Enable  = 1'b0;
      IF_ID_flush    = 1'b0;
      ID_EX_flush    = 1'b0;
      MEM_WB_flush   = 1'b0;
      MemError       = 1'b0;
      redirect_taken = 1'b0;
    end
  end

  assign stall_inc = !PC_Enable && (state != ST_FAULT);

  // Saturating performance counters.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      StallCycles   <= CNT_W'(STALL_CNT_RST);
      RedirectCount <= CNT_W'(REDIRECT_CNT_RST);
    end else begin
      if (stall_inc && (StallCycles != '1)) begin
        StallCycles <= StallCycles + CNT_W'(1);
      end
      if (redirect_taken && (RedirectCount != '1)) begin
        RedirectCount <= RedirectCount + CNT_W'(1);
      end
    end
  end

endmodule
